// File: rtl/parking_pkg.sv
// Shared types and slot-search helpers for the car-park entry allocator.
// Holds slot sizing, the FSM state enum and priority-search functions.
package parking_pkg;

  localparam int NUM_SLOTS_DEFAULT = 8;
  localparam int SLOT_W = $clog2(NUM_SLOTS_DEFAULT);

  typedef logic [NUM_SLOTS_DEFAULT-1:0] slot_map_t;

  typedef enum logic {
    ST_IDLE,
    ST_OPEN
  } state_e;

  function automatic logic [SLOT_W-1:0] lowest_set(
    input slot_map_t v
  );
    logic [SLOT_W-1:0] r;
    r = '0;
    for (int i = NUM_SLOTS_DEFAULT - 1; i >= 0; i--) begin
      if (v[i]) r = SLOT_W'(i);
    end
    return r;
  endfunction

  // First set bit at or after start, wrapping around the map.
  function automatic logic [SLOT_W-1:0] wrap_search(
    input slot_map_t         v,
    input logic [SLOT_W-1:0] start
  );
    logic [SLOT_W-1:0] r;
    int idx;
    r = '0;
    for (int k = NUM_SLOTS_DEFAULT - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NUM_SLOTS_DEFAULT;
      if (v[idx]) r = SLOT_W'(idx);
    end
    return r;
  endfunction

endpackage

// File: rtl/parking_resv_timer.sv
// One slot's reservation bit with its hold-time down-counter.
// Ports: clk, rst (sync, active-high), set, occupied -> reserved.
module parking_resv_timer
  import parking_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic occupied,
  output logic reserved
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          resv_q, resv_d;
  logic [TW-1:0] tmr_q, tmr_d;

  // set is only raised for a free slot, so it never
  // collides with the release paths below.
  always_comb begin
    resv_d = resv_q;
    tmr_d  = tmr_q;
    if (set) begin
      resv_d = 1'b1;
      tmr_d  = TW'(TIMEOUT);
    end else if (resv_q && occupied) begin
      resv_d = 1'b0;
      tmr_d  = '0;
    end else if (tmr_q == TW'(1)) begin
      resv_d = 1'b0;
      tmr_d  = '0;
    end else if (resv_q) begin
      tmr_d  = tmr_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resv_q <= 1'b0;
      tmr_q  <= '0;
    end else begin
      resv_q <= resv_d;
      tmr_q  <= tmr_d;
    end
  end

  assign reserved = resv_q;

endmodule

// File: rtl/parking_slot_allocator.sv
// Car-park entry controller: reserves a free slot per car, drives the gate.
// Ports: occupied/entry_valid in; entry_ready, grant_*, gate_open, full, free_count out.
// Build option PARKING_ROUND_ROBIN_EN: rotate selection start after each grant.
module parking_slot_allocator
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS        = NUM_SLOTS_DEFAULT,
  parameter int RESV_TIMEOUT     = 16,
  parameter int GATE_OPEN_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SLOTS-1:0]         occupied,
  input  logic                         entry_valid,
  output logic                         entry_ready,
  output logic                         grant_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] grant_slot,
  output logic                         gate_open,
  output logic                         full,
  output logic [$clog2(NUM_SLOTS):0]   free_count
);

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int GW = $clog2(GATE_OPEN_CYCLES + 1);

  logic [NUM_SLOTS-1:0] reserved;
  logic [NUM_SLOTS-1:0] set_vec;
  logic [NUM_SLOTS-1:0] free_map;
  logic [SW-1:0]        sel_slot;
  logic                 accept;

  state_e        state_q, state_d;
  logic [GW-1:0] cnt_q, cnt_d;
  logic          gv_q, gv_d;
  logic [SW-1:0] gs_q, gs_d;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    parking_resv_timer #(
      .TIMEOUT (RESV_TIMEOUT)
    ) u_tmr (
      .clk      (clk),
      .rst      (rst),
      .set      (set_vec[g]),
      .occupied (occupied[g]),
      .reserved (reserved[g])
    );
  end

  assign free_map = ~occupied & ~reserved;
  assign full     = (free_map == '0);

  always_comb begin
    free_count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_count = free_count + {{SW{1'b0}}, free_map[i]};
    end
  end

`ifdef PARKING_ROUND_ROBIN_EN
  logic [SW-1:0] ptr_q, ptr_d;

  assign sel_slot = wrap_search(free_map, ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (sel_slot == SW'(NUM_SLOTS - 1)) ?
              '0 : sel_slot + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  assign sel_slot = lowest_set(free_map);
`endif

  always_comb begin
    set_vec = '0;
    if (accept) set_vec[sel_slot] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gv_d        = 1'b0;
    gs_d        = gs_q;
    entry_ready = 1'b0;
    accept      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        entry_ready = !rst && !full;
        accept      = entry_valid && entry_ready;
        if (accept) begin
          state_d = ST_OPEN;
          cnt_d   = GW'(GATE_OPEN_CYCLES - 1);
          gv_d    = 1'b1;
          gs_d    = sel_slot;
        end
      end
      ST_OPEN: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gv_q    <= 1'b0;
      gs_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gv_q    <= gv_d;
      gs_q    <= gs_d;
    end
  end

  assign gate_open   = (state_q == ST_OPEN);
  assign grant_valid = gv_q;
  assign grant_slot  = gs_q;

endmodule
